// File: rtl/branch_resolve_ras_if.sv
// Bus between the fetch/decode side and the branch resolution unit.
// master drives the instruction and flags; slave (the unit) returns the redirect.
interface branch_resolve_ras_if #(
   parameter int unsigned AW        = 32,
   parameter int unsigned JW        = 26,
   parameter int unsigned RAS_DEPTH = 8
);
   localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

   logic          in_valid;
   logic          stall;
   logic          flush;
   logic [5:0]    opcode;
   logic [3:0]    fn;
   logic [JW-1:0] jtr;
   logic [AW-1:0] pc;
   logic [AW-1:0] rs_data;
   logic [AW-1:0] link_data;
   logic          zflag;
   logic          carryflag;
   logic          signflag;
   logic          overflowflag;

   logic          out_valid;
   logic          taken;
   logic [AW-1:0] target;
   logic [AW-1:0] pc_offset;
   logic [CW-1:0] ras_count;
   logic          ras_overflow;
   logic          ras_underflow;

   modport master (
      output in_valid, stall, flush, opcode, fn, jtr, pc, rs_data, link_data,
             zflag, carryflag, signflag, overflowflag,
      input  out_valid, taken, target, pc_offset, ras_count, ras_overflow, ras_underflow
   );

   modport slave (
      input  in_valid, stall, flush, opcode, fn, jtr, pc, rs_data, link_data,
             zflag, carryflag, signflag, overflowflag,
      output out_valid, taken, target, pc_offset, ras_count, ras_overflow, ras_underflow
   );
endinterface

// File: rtl/branch_resolve_ras.sv
// Branch resolution unit with an internal circular return-address stack.
// Results are registered: one cycle from accepted instruction to out_valid.
// Assumes AW > JW + 2 and RAS_DEPTH a power of two.
module branch_resolve_ras #(
   parameter int unsigned AW        = 32,
   parameter int unsigned JW        = 26,
   parameter int unsigned RAS_DEPTH = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   branch_resolve_ras_if.slave bus
);
   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] Full = CW'(RAS_DEPTH);

   logic [AW-1:0] stack_q [RAS_DEPTH];
   logic [PW-1:0] sp_q, sp_d;
   logic [CW-1:0] count_q, count_d;

   logic          out_valid_q, out_valid_d;
   logic          taken_q, taken_d;
   logic [AW-1:0] target_q, target_d;
   logic [AW-1:0] pc_offset_q, pc_offset_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   logic [3:0]    op;
   logic [AW-1:0] seq, imm, rel, ret_addr, tgt;
   logic          take, is_call, is_ret, push;
   logic          unused_opcode_hi;

   assign op               = bus.opcode[3:0];
   assign unused_opcode_hi = ^bus.opcode[5:4];
   assign seq              = bus.pc + AW'(4);
   assign imm              = {{(AW-JW-2){bus.jtr[JW-1]}}, bus.jtr, 2'b00};
   assign rel              = seq + imm;
   // Under flush the stack is being discarded, so a return falls back to the link register.
   assign ret_addr = (!bus.flush && count_q != '0) ? stack_q[sp_q] : bus.link_data;

   // Decode: taken condition and candidate target per opcode.
   always_comb begin
      take    = 1'b0;
      tgt     = rel;
      is_call = 1'b0;
      is_ret  = 1'b0;
      case (op)
         4'b0000: begin
            take = (bus.fn == 4'b1010);
            tgt  = bus.rs_data;
         end
         4'b0101: take = 1'b1;
         4'b0110: take = bus.zflag;
         4'b0111: take = ~bus.zflag;
         4'b1000: take = bus.carryflag;
         4'b1001: take = ~bus.carryflag;
         4'b1010: take = bus.signflag;
         4'b1011: take = ~bus.signflag;
         4'b1100: take = bus.overflowflag;
         4'b1101: take = ~bus.overflowflag;
         4'b1110: begin
            take    = 1'b1;
            is_call = 1'b1;
         end
         4'b1111: begin
            take   = 1'b1;
            is_ret = 1'b1;
            tgt    = ret_addr;
         end
         default: take = 1'b0;
      endcase
   end

   // Next state: stack pointer/count updates and registered results.
   always_comb begin
      sp_d        = sp_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      taken_d     = taken_q;
      target_d    = target_q;
      pc_offset_d = pc_offset_q;
      ovf_d       = 1'b0;
      unf_d       = 1'b0;
      push        = 1'b0;
      if (!bus.stall) begin
         out_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            taken_d     = take;
            target_d    = take ? tgt : seq;
            pc_offset_d = take ? (tgt - seq) : '0;
            if (!bus.flush) begin
               if (is_call) begin
                  push = 1'b1;
                  sp_d = sp_q + PW'(1);
                  if (count_q == Full) begin
                     ovf_d = 1'b1;
                  end else begin
                     count_d = count_q + CW'(1);
                  end
               end else if (is_ret) begin
                  if (count_q != '0) begin
                     sp_d    = sp_q - PW'(1);
                     count_d = count_q - CW'(1);
                  end else begin
                     unf_d = 1'b1;
                  end
               end
            end
         end
      end
      // Flush clears the stack even while stalled.
      if (bus.flush) begin
         sp_d    = '0;
         count_d = '0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q        <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         taken_q     <= 1'b0;
         target_q    <= '0;
         pc_offset_q <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         sp_q        <= sp_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         taken_q     <= taken_d;
         target_q    <= target_d;
         pc_offset_q <= pc_offset_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   // Stack storage: contents need no reset; a push when full overwrites the oldest slot.
   always_ff @(posedge clk) begin
      if (push) begin
         stack_q[sp_q + PW'(1)] <= seq;
      end
   end

   assign bus.out_valid     = out_valid_q;
   assign bus.taken         = taken_q;
   assign bus.target        = target_q;
   assign bus.pc_offset     = pc_offset_q;
   assign bus.ras_count     = count_q;
   assign bus.ras_overflow  = ovf_q;
   assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_branch_resolve_ras.sv
// Scoreboard bench: stimulus pushes expected results, per-DUT monitors pop and compare.
// dut_a: AW=32 JW=26 depth 4; dut_b: AW=16 JW=10 depth 4 for wrap checks.
module tb_branch_resolve_ras;
   localparam int unsigned D = 4;

   typedef struct {
      string       name;
      logic        taken;
      logic [31:0] target;
      logic [31:0] off;
      logic [2:0]  cnt;
      logic        ovf;
      logic        unf;
   } exp_t;

   localparam logic [3:0] NF = 4'b0000;
   localparam logic [3:0] FZ = 4'b1000;
   localparam logic [3:0] FC = 4'b0100;
   localparam logic [3:0] FO = 4'b0001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;

   branch_resolve_ras_if #(.AW(32), .JW(26), .RAS_DEPTH(D)) bus_a ();
   branch_resolve_ras_if #(.AW(16), .JW(10), .RAS_DEPTH(D)) bus_b ();

   branch_resolve_ras #(.AW(32), .JW(26), .RAS_DEPTH(D)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   branch_resolve_ras #(.AW(16), .JW(10), .RAS_DEPTH(D)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   task automatic cmp(exp_t e, logic tk, logic [31:0] tg, logic [31:0] of, logic [2:0] cn,
                      logic ov, logic un);
      chk({e.name, ".taken"}, 32'(tk), 32'(e.taken));
      chk({e.name, ".target"}, tg, e.target);
      chk({e.name, ".pc_offset"}, of, e.off);
      chk({e.name, ".ras_count"}, 32'(cn), 32'(e.cnt));
      chk({e.name, ".ras_overflow"}, 32'(ov), 32'(e.ovf));
      chk({e.name, ".ras_underflow"}, 32'(un), 32'(e.unf));
   endtask

   // Monitor for dut_a.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && bus_a.out_valid) begin
         if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected: out_valid with target 0x%0h, required no output",
                     bus_a.target);
         end else begin
            e = q_a.pop_front();
            cmp(e, bus_a.taken, bus_a.target, bus_a.pc_offset, bus_a.ras_count,
                bus_a.ras_overflow, bus_a.ras_underflow);
         end
      end
   end

   // Monitor for dut_b.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && bus_b.out_valid) begin
         if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected: out_valid with target 0x%0h, required no output",
                     bus_b.target);
         end else begin
            e = q_b.pop_front();
            cmp(e, bus_b.taken, {16'h0, bus_b.target}, {16'h0, bus_b.pc_offset},
                bus_b.ras_count, bus_b.ras_overflow, bus_b.ras_underflow);
         end
      end
   end

   task automatic idle_a();
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      bus_a.stall    = 1'b0;
      bus_a.flush    = 1'b0;
   endtask

   // flags = {z, carry, sign, overflow}; nothing is expected when stalled.
   task automatic issue_a(string name, logic [5:0] opc, logic [3:0] f, logic [25:0] j,
                          logic [31:0] p, logic [3:0] flags, logic st, logic fl,
                          logic tk, logic [31:0] tg, logic [2:0] cn, logic ov, logic un);
      exp_t e;
      @(negedge clk);
      bus_a.in_valid     = 1'b1;
      bus_a.opcode       = opc;
      bus_a.fn           = f;
      bus_a.jtr          = j;
      bus_a.pc           = p;
      bus_a.zflag        = flags[3];
      bus_a.carryflag    = flags[2];
      bus_a.signflag     = flags[1];
      bus_a.overflowflag = flags[0];
      bus_a.stall        = st;
      bus_a.flush        = fl;
      if (!st) begin
         e.name   = name;
         e.taken  = tk;
         e.target = tg;
         e.off    = tk ? (tg - (p + 32'd4)) : 32'd0;
         e.cnt    = cn;
         e.ovf    = ov;
         e.unf    = un;
         q_a.push_back(e);
      end
   endtask

   task automatic issue_b(string name, logic [5:0] opc, logic [9:0] j, logic [15:0] p,
                          logic z, logic tk, logic [15:0] tg, logic [2:0] cn);
      exp_t e;
      logic [15:0] off;
      @(negedge clk);
      bus_b.in_valid = 1'b1;
      bus_b.opcode   = opc;
      bus_b.jtr      = j;
      bus_b.pc       = p;
      bus_b.zflag    = z;
      off            = tk ? (tg - (p + 16'd4)) : 16'd0;
      e.name   = name;
      e.taken  = tk;
      e.target = {16'h0, tg};
      e.off    = {16'h0, off};
      e.cnt    = cn;
      e.ovf    = 1'b0;
      e.unf    = 1'b0;
      q_b.push_back(e);
   endtask

   task automatic chk_zero(string name);
      chk({name, ".out_valid"}, 32'(bus_a.out_valid), 32'd0);
      chk({name, ".taken"}, 32'(bus_a.taken), 32'd0);
      chk({name, ".target"}, bus_a.target, 32'd0);
      chk({name, ".pc_offset"}, bus_a.pc_offset, 32'd0);
      chk({name, ".ras_count"}, 32'(bus_a.ras_count), 32'd0);
      chk({name, ".pulses"}, 32'({bus_a.ras_overflow, bus_a.ras_underflow}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_a.in_valid = 0; bus_a.stall = 0; bus_a.flush = 0; bus_a.opcode = '0;
      bus_a.fn = '0; bus_a.jtr = '0; bus_a.pc = '0; bus_a.rs_data = 32'h2000;
      bus_a.link_data = 32'hABC; bus_a.zflag = 0; bus_a.carryflag = 0;
      bus_a.signflag = 0; bus_a.overflowflag = 0;
      bus_b.in_valid = 0; bus_b.stall = 0; bus_b.flush = 0; bus_b.opcode = '0;
      bus_b.fn = '0; bus_b.jtr = '0; bus_b.pc = '0; bus_b.rs_data = 16'h0;
      bus_b.link_data = 16'h0ABC; bus_b.zflag = 0; bus_b.carryflag = 0;
      bus_b.signflag = 0; bus_b.overflowflag = 0;

      #12;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Conditional, unconditional and register jumps.
      issue_a("cond_z1",  6'h06, 4'h0, 26'h3FFFFFE, 32'h100, FZ, 0, 0, 1, 32'h0FC, 0, 0, 0);
      issue_a("cond_z0",  6'h06, 4'h0, 26'h3FFFFFE, 32'h100, NF, 0, 0, 0, 32'h104, 0, 0, 0);
      issue_a("bnz_z0",   6'h07, 4'h0, 26'd4, 32'h200, NF, 0, 0, 1, 32'h214, 0, 0, 0);
      issue_a("bc_c1",    6'h08, 4'h0, 26'd4, 32'h200, FC, 0, 0, 1, 32'h214, 0, 0, 0);
      issue_a("bnc_c1",   6'h09, 4'h0, 26'd4, 32'h200, FC, 0, 0, 0, 32'h204, 0, 0, 0);
      issue_a("bs_s0",    6'h0A, 4'h0, 26'd4, 32'h200, NF, 0, 0, 0, 32'h204, 0, 0, 0);
      issue_a("bns_s0",   6'h0B, 4'h0, 26'd4, 32'h200, NF, 0, 0, 1, 32'h214, 0, 0, 0);
      issue_a("bv_o1",    6'h0C, 4'h0, 26'd4, 32'h200, FO, 0, 0, 1, 32'h214, 0, 0, 0);
      issue_a("bnv_o1",   6'h0D, 4'h0, 26'd4, 32'h200, FO, 0, 0, 0, 32'h204, 0, 0, 0);
      issue_a("jr",       6'h00, 4'hA, 26'd0, 32'h40, NF, 0, 0, 1, 32'h2000, 0, 0, 0);
      issue_a("jr_badfn", 6'h00, 4'h1, 26'd0, 32'h40, NF, 0, 0, 0, 32'h44, 0, 0, 0);
      issue_a("jmp_hi",   6'h35, 4'h0, 26'd4, 32'h200, NF, 0, 0, 1, 32'h214, 0, 0, 0);
      issue_a("undef",    6'h03, 4'h0, 26'd4, 32'h200, NF, 0, 0, 0, 32'h204, 0, 0, 0);

      // Nested calls and returns.
      issue_a("call1", 6'h0E, 4'h0, 26'd4, 32'h10, NF, 0, 0, 1, 32'h24, 1, 0, 0);
      issue_a("call2", 6'h0E, 4'h0, 26'd4, 32'h20, NF, 0, 0, 1, 32'h34, 2, 0, 0);
      issue_a("call3", 6'h0E, 4'h0, 26'd4, 32'h30, NF, 0, 0, 1, 32'h44, 3, 0, 0);
      issue_a("ret3",  6'h0F, 4'h0, 26'd0, 32'h500, NF, 0, 0, 1, 32'h34, 2, 0, 0);
      issue_a("ret2",  6'h0F, 4'h0, 26'd0, 32'h500, NF, 0, 0, 1, 32'h24, 1, 0, 0);
      issue_a("ret1",  6'h0F, 4'h0, 26'd0, 32'h500, NF, 0, 0, 1, 32'h14, 0, 0, 0);

      // Overflow then underflow on a depth-4 stack.
      for (int i = 1; i <= 5; i++) begin
         issue_a($sformatf("ovf_call%0d", i), 6'h0E, 4'h0, 26'd0, 32'(i * 32'h100), NF, 0, 0,
                 1, 32'(i * 32'h100 + 4), 3'((i > 4) ? 4 : i), (i == 5), 0);
      end
      for (int i = 5; i >= 2; i--) begin
         issue_a($sformatf("ovf_ret%0d", i), 6'h0F, 4'h0, 26'd0, 32'h800, NF, 0, 0,
                 1, 32'(i * 32'h100 + 4), 3'(i - 2), 0, 0);
      end
      issue_a("unf_ret",   6'h0F, 4'h0, 26'd0, 32'h800, NF, 0, 0, 1, 32'hABC, 0, 0, 1);
      issue_a("after_unf", 6'h03, 4'h0, 26'd0, 32'h800, NF, 0, 0, 0, 32'h804, 0, 0, 0);

      // Back-to-back call then return.
      issue_a("b2b_call", 6'h0E, 4'h0, 26'd0, 32'h60, NF, 0, 0, 1, 32'h64, 1, 0, 0);
      issue_a("b2b_ret",  6'h0F, 4'h0, 26'd0, 32'h900, NF, 0, 0, 1, 32'h64, 0, 0, 0);

      // Stall, then flush with three entries live.
      issue_a("sf_call1", 6'h0E, 4'h0, 26'd0, 32'h1000, NF, 0, 0, 1, 32'h1004, 1, 0, 0);
      issue_a("sf_call2", 6'h0E, 4'h0, 26'd0, 32'h2000, NF, 0, 0, 1, 32'h2004, 2, 0, 0);
      issue_a("sf_call3", 6'h0E, 4'h0, 26'd0, 32'h3000, NF, 0, 0, 1, 32'h3004, 3, 0, 0);
      idle_a();
      issue_a("stall_call", 6'h0E, 4'h0, 26'd0, 32'h4000, NF, 1, 0, 0, 32'h0, 0, 0, 0);
      @(posedge clk);
      #2;
      chk("stall.ras_count", 32'(bus_a.ras_count), 32'd3);
      chk("stall.out_valid", 32'(bus_a.out_valid), 32'd0);
      issue_a("flush_ret",  6'h0F, 4'h0, 26'd0, 32'h700, NF, 0, 1, 1, 32'hABC, 0, 0, 0);
      issue_a("post_flush", 6'h0F, 4'h0, 26'd0, 32'h700, NF, 0, 0, 1, 32'hABC, 0, 0, 1);
      issue_a("flush_call", 6'h0E, 4'h0, 26'd4, 32'h100, NF, 0, 1, 1, 32'h114, 0, 0, 0);
      issue_a("fc_ret",     6'h0F, 4'h0, 26'd0, 32'h700, NF, 0, 0, 1, 32'hABC, 0, 0, 1);

      // Stall together with flush still clears the stack.
      issue_a("sfl_call", 6'h0E, 4'h0, 26'd0, 32'h100, NF, 0, 0, 1, 32'h104, 1, 0, 0);
      idle_a();
      issue_a("stall_flush", 6'h0E, 4'h0, 26'd0, 32'h200, NF, 1, 1, 0, 32'h0, 0, 0, 0);
      @(posedge clk);
      #2;
      chk("stall_flush.ras_count", 32'(bus_a.ras_count), 32'd0);
      chk("stall_flush.out_valid", 32'(bus_a.out_valid), 32'd0);

      // Asynchronous reset in the middle of a cycle.
      issue_a("pre_rst", 6'h0E, 4'h0, 26'd4, 32'h100, NF, 0, 0, 1, 32'h114, 1, 0, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      idle_a();
      rst_n = 1'b1;

      // Narrow build: modulo 2^16 wraps.
      issue_b("b_wrap",    6'h05, 10'h1FF, 16'hFFF0, 0, 1, 16'h07F0, 0);
      issue_b("b_nt_wrap", 6'h06, 10'h000, 16'hFFFC, 0, 0, 16'h0000, 0);
      issue_b("b_call",    6'h0E, 10'h3FF, 16'hFFFC, 0, 1, 16'hFFFC, 1);
      issue_b("b_ret",     6'h0F, 10'h000, 16'h1000, 0, 1, 16'h0000, 0);
      @(negedge clk);
      bus_b.in_valid = 1'b0;

      repeat (3) @(posedge clk);
      #2;
      chk("q_a_drained", 32'(q_a.size()), 32'd0);
      chk("q_b_drained", 32'(q_b.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_resolve_ras.md
Name: branch_resolve_ras

Overview:
- Parametrised next-generation branch resolution unit for the RISC core.
- Resolves jumps, flag-conditional branches, calls, register jumps and returns using the existing op/fn encoding.
- Adds an internal return-address stack (RAS) of configurable depth; the return path no longer needs a register-bank read of the link register.
- Results are registered with one-cycle latency; the fetch stage consumes `taken`/`target` on `out_valid`.

Parameters:
- AW, 32: address/data width of `pc`, `rs_data`, `target` and `pc_offset`.
- JW, 26: width of the jump/branch immediate field.
- RAS_DEPTH, 8: return-address stack entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction presented this cycle
- stall  in  1  freeze: inputs ignored, all state and outputs held
- flush  in  1  synchronous stack clear; wins over in_valid
- opcode  in  6  instruction opcode; only [3:0] decoded
- fn  in  4  function field (register-jump select)
- jtr  in  JW  immediate, word units, two's complement
- pc  in  AW  byte address of the current instruction
- rs_data  in  AW  register-jump source (byte address)
- link_data  in  AW  register-bank link value, fallback for return on empty stack
- zflag, carryflag, signflag, overflowflag  in  1 each  ALU flags
- out_valid  out  1  result valid (registered)
- taken  out  1  redirect fetch
- target  out  AW  absolute redirect address
- pc_offset  out  AW  target − (pc+4); 0 when not taken
- ras_count  out  clog2(RAS_DEPTH)+1  live stack entries
- ras_overflow  out  1  one-cycle pulse: push dropped the oldest entry
- ras_underflow  out  1  one-cycle pulse: return on empty stack

Behaviour:
- Reset (async, rst_n low): out_valid=0, taken=0, target=0, pc_offset=0, ras_count=0, both pulses=0, stack pointer=0. Stack contents are don't-care.
- Latency: inputs sampled at edge N when in_valid=1 and stall=0; outputs valid after edge N. out_valid deasserts the following cycle unless a new instruction is accepted.
- Arithmetic:
  - seq = pc+4, modulo 2^AW.
  - imm = {jtr, 2'b00} sign-extended to AW.
  - Relative target = seq + imm.
  - All wraps are modulo 2^AW.
- Decode by op = opcode[3:0]:
  - 0000 with fn=1010: register jump. target = rs_data, taken=1. Any other fn: not taken.
  - 0101: unconditional relative jump.
  - 0110/0111: taken if z=1 / z=0.
  - 1000/1001: taken if carry=1 / carry=0.
  - 1010/1011: taken if sign=1 / sign=0.
  - 1100/1101: taken if overflow=1 / overflow=0.
  - 1110: call. Relative jump taken; push seq.
  - 1111: return. Pop; target = popped value, taken=1.
  - Undefined codes: not taken.
- When not taken: target = seq, pc_offset = 0.
- RAS implementation: circular buffer, top-of-stack pointer sp, and count.
  - Push: write at sp+1 (mod depth), advance sp, count saturates at RAS_DEPTH.
  - Push when full: overwrite oldest entry, ras_overflow pulse.
- Pop:
  - count>0: read entry at sp, decrement sp and count.
  - count==0: target = link_data, ras_underflow pulse, pointer and count unchanged.
- Ordering: a push is visible to a pop on the next accepted instruction (back-to-back call then return returns the new seq). No same-cycle bypass is needed, since one instruction is accepted per cycle.
- flush=1: count←0 and sp←0. The instruction in the same cycle is resolved normally except that its stack effects are discarded. A return under flush uses link_data and raises no underflow pulse.
- stall=1: nothing changes, and pulses do not repeat. stall together with flush: flush still applies.
- Reset mid-operation clears everything immediately, regardless of clock.

Test Plan:
- Conditional branches: pc=0x100, jtr=0x3FFFFFE (−2), op=0110, z=1 → taken=1, target=0x0FC, pc_offset=0xFFFFFFF8. Same with z=0 → taken=0, target=0x104, pc_offset=0.
- Register jump: op=0000, fn=1010, rs_data=0x2000, pc=0x40 → target=0x2000, pc_offset=0x1FBC. Same op with fn=0001 → not taken.
- Call/return nesting: calls at pc=0x10, 0x20, 0x30 (jtr=4), then three returns → targets 0x34, 0x24, 0x14; ras_count 3→0; no pulses.
- Overflow/underflow with RAS_DEPTH=4: 5 calls → overflow pulse on the 5th, count=4. 5 returns → 4 most recent return addresses in LIFO order, then the 5th returns link_data=0xABC with an underflow pulse.
- Stall/flush/reset:
  - Call with stall=1 → count unchanged, outputs held.
  - Flush with 3 entries → count=0.
  - rst_n low mid-stream → all outputs zero asynchronously, before the next clock edge.
- Sweep: AW=16, JW=10 build; imm=0x1FF from pc=0xFFF0 wraps modulo 2^16 → target=0x07F0.
